// File: rtl/cam_frame_writer.sv
// Camera-to-framebuffer writer: assembles 2-byte pixels, converts to RGB332, decimates,
// and emits registered write strobes plus per-frame status for the dual-port frame buffer.
module cam_frame_writer #(
    parameter int SCREEN_WIDTH  = 176,
    parameter int SCREEN_HEIGHT = 144,
    parameter int ADDR_W        = 15,
    parameter int H_DECIM       = 1,
    parameter int V_DECIM       = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [7:0]        D,
    input  logic              HREF,
    input  logic              VSYNC,
    input  logic              FMT,
    input  logic              CAPTURE_EN,
    output logic [7:0]        W_DATA,
    output logic [ADDR_W-1:0] W_ADDR,
    output logic              W_EN,
    output logic              FRAME_DONE,
    output logic [7:0]        FRAME_COUNT,
    output logic              LINE_OVF,
    output logic              FRAME_OVF
);

    localparam int XW = $clog2(SCREEN_WIDTH + 1);
    localparam int YW = $clog2(SCREEN_HEIGHT + 1);
    localparam int HW = (H_DECIM > 1) ? $clog2(H_DECIM) : 1;
    localparam int VW = (V_DECIM > 1) ? $clog2(V_DECIM) : 1;

    typedef enum logic [1:0] {IDLE, VBLANK, ACTIVE} state_t;

    state_t            state, state_nx;
    logic              fmt_q, cap_q;
    logic              phase, href_q, line_kept;
    logic [7:0]        b0_q;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] row_base;
    logic [HW-1:0]     hcnt;
    logic [VW-1:0]     vcnt;
    logic [1:0]        vld_pipe;
    logic [7:0]        wr_data;
    logic [ADDR_W-1:0] wr_addr;

    logic              frame_start, frame_end, byte_vld, line_end;
    logic              pix_done, pix_keep, pix_wr, x_full, y_full;
    logic [7:0]        pix_rgb;

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (VSYNC)  state_nx = VBLANK;
            VBLANK:  if (!VSYNC) state_nx = ACTIVE;
            ACTIVE:  if (VSYNC)  state_nx = VBLANK;
            default: state_nx = IDLE;
        endcase
    end

    // VSYNC has priority over HREF while active, so a frame end always discards the partial line.
    always_comb begin
        frame_start = (state == VBLANK) && !VSYNC;
        frame_end   = (state == ACTIVE) && VSYNC;
        byte_vld    = (state == ACTIVE) && !VSYNC && HREF;
        line_end    = (state == ACTIVE) && !VSYNC && !HREF && href_q;
        pix_done    = byte_vld && phase;
        x_full      = (x >= XW'(SCREEN_WIDTH));
        y_full      = (y >= YW'(SCREEN_HEIGHT));
        pix_keep    = pix_done && (hcnt == '0) && (vcnt == '0) && cap_q;
        pix_wr      = pix_keep && !x_full && !y_full;
        if (fmt_q) pix_rgb = {b0_q[3:1], D[7:5], D[3:2]};
        else       pix_rgb = {b0_q[7:5], b0_q[2:0], D[4:3]};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            fmt_q     <= 1'b0;
            cap_q     <= 1'b0;
            phase     <= 1'b0;
            href_q    <= 1'b0;
            line_kept <= 1'b0;
            b0_q      <= '0;
            x         <= '0;
            y         <= '0;
            row_base  <= '0;
            hcnt      <= '0;
            vcnt      <= '0;
            LINE_OVF  <= 1'b0;
            FRAME_OVF <= 1'b0;
        end else begin
            href_q <= HREF && (state == ACTIVE) && !VSYNC;
            if (frame_start) begin
                fmt_q     <= FMT;
                cap_q     <= CAPTURE_EN;
                phase     <= 1'b0;
                line_kept <= 1'b0;
                x         <= '0;
                y         <= '0;
                row_base  <= '0;
                hcnt      <= '0;
                vcnt      <= '0;
                LINE_OVF  <= 1'b0;
                FRAME_OVF <= 1'b0;
            end else if (byte_vld) begin
                phase <= ~phase;
                if (!phase) b0_q <= D;
                if (pix_done) begin
                    hcnt <= (hcnt == HW'(H_DECIM - 1)) ? '0 : hcnt + 1'b1;
                    if (pix_keep && y_full)
                        FRAME_OVF <= 1'b1;
                    else if (pix_keep && x_full)
                        LINE_OVF <= 1'b1;
                    if (pix_wr) begin
                        x         <= x + 1'b1;
                        line_kept <= 1'b1;
                    end
                end
            end else if (line_end) begin
                // Odd trailing byte is dropped by forcing phase back to byte0.
                phase     <= 1'b0;
                x         <= '0;
                hcnt      <= '0;
                line_kept <= 1'b0;
                vcnt      <= (vcnt == VW'(V_DECIM - 1)) ? '0 : vcnt + 1'b1;
                if ((vcnt == '0) && line_kept) begin
                    y        <= y + 1'b1;
                    row_base <= row_base + ADDR_W'(SCREEN_WIDTH);
                end
            end
        end
    end

    // Two-stage write pipe: pixel captured on the byte1 edge, presented one edge later.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            vld_pipe    <= '0;
            wr_data     <= '0;
            wr_addr     <= '0;
            W_DATA      <= '0;
            W_ADDR      <= '0;
            FRAME_DONE  <= 1'b0;
            FRAME_COUNT <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], pix_wr};
            if (pix_wr) begin
                wr_data <= pix_rgb;
                wr_addr <= row_base + ADDR_W'(x);
            end
            if (vld_pipe[0]) begin
                W_DATA <= wr_data;
                W_ADDR <= wr_addr;
            end
            FRAME_DONE <= frame_end && cap_q;
            if (frame_end && cap_q) FRAME_COUNT <= FRAME_COUNT + 8'd1;
        end
    end

    assign W_EN = vld_pipe[1];

endmodule

// File: tb/tb_cam_frame_writer.sv
// Directed bench for cam_frame_writer using a reduced 8x6 screen and a 2x2-decimating twin.
module tb_cam_frame_writer;

    logic        CLK = 1'b0;
    logic        RESET, HREF, VSYNC, FMT, CAPTURE_EN;
    logic [7:0]  D;
    logic [7:0]  W_DATA, FRAME_COUNT;
    logic [14:0] W_ADDR;
    logic        W_EN, FRAME_DONE, LINE_OVF, FRAME_OVF;
    logic [7:0]  w_data2, frame_count2;
    logic [5:0]  w_addr2;
    logic        w_en2, frame_done2, line_ovf2, frame_ovf2;

    cam_frame_writer #(.SCREEN_WIDTH(8), .SCREEN_HEIGHT(6), .ADDR_W(15)) dut (
        .CLK(CLK), .RESET(RESET), .D(D), .HREF(HREF), .VSYNC(VSYNC), .FMT(FMT),
        .CAPTURE_EN(CAPTURE_EN), .W_DATA(W_DATA), .W_ADDR(W_ADDR), .W_EN(W_EN),
        .FRAME_DONE(FRAME_DONE), .FRAME_COUNT(FRAME_COUNT), .LINE_OVF(LINE_OVF),
        .FRAME_OVF(FRAME_OVF));

    cam_frame_writer #(.SCREEN_WIDTH(8), .SCREEN_HEIGHT(6), .ADDR_W(6),
                       .H_DECIM(2), .V_DECIM(2)) dut2 (
        .CLK(CLK), .RESET(RESET), .D(D), .HREF(HREF), .VSYNC(VSYNC), .FMT(FMT),
        .CAPTURE_EN(CAPTURE_EN), .W_DATA(w_data2), .W_ADDR(w_addr2), .W_EN(w_en2),
        .FRAME_DONE(frame_done2), .FRAME_COUNT(frame_count2), .LINE_OVF(line_ovf2),
        .FRAME_OVF(frame_ovf2));

    always #5 CLK = ~CLK;

    typedef struct {
        logic       fmt;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] exp;
    } cvec_t;

    int          n_chk = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    int          exp_count = 0;
    logic [22:0] wq[$];
    logic [13:0] wq2[$];

    always @(negedge CLK) begin
        if (W_EN)       wq.push_back({W_ADDR, W_DATA});
        if (w_en2)      wq2.push_back({w_addr2, w_data2});
        if (FRAME_DONE) done_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_frame(input logic fmt, input logic cap);
        HREF = 1'b0; VSYNC = 1'b1; FMT = fmt; CAPTURE_EN = cap;
        repeat (3) step();
        VSYNC = 1'b0;
        step();
        step();
    endtask

    task automatic send_px(input logic [7:0] b0, input logic [7:0] b1);
        HREF = 1'b1; D = b0;
        step();
        D = b1;
        step();
    endtask

    task automatic line_end();
        HREF = 1'b0;
        step();
        step();
    endtask

    task automatic end_frame();
        HREF = 1'b0; VSYNC = 1'b1;
        repeat (4) step();
    endtask

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        cvec_t       cv[6];
        logic [22:0] e;
        int          d0, bad, hits, hit_addr;

        cv[0] = '{1'b0, 8'hF8, 8'h00, 8'hE0};
        cv[1] = '{1'b0, 8'h07, 8'h18, 8'h1F};
        cv[2] = '{1'b0, 8'hA5, 8'h5A, 8'hB7};
        cv[3] = '{1'b1, 8'h0F, 8'hF0, 8'hFC};
        cv[4] = '{1'b1, 8'hF5, 8'h3C, 8'h47};
        cv[5] = '{1'b1, 8'h0E, 8'hAA, 8'hF6};

        RESET = 1'b1; D = '0; HREF = 1'b0; VSYNC = 1'b0; FMT = 1'b0; CAPTURE_EN = 1'b1;
        repeat (3) step();
        chk("rst_w_en",    32'(W_EN), 0);
        chk("rst_w_data",  32'(W_DATA), 0);
        chk("rst_w_addr",  32'(W_ADDR), 0);
        chk("rst_done",    32'(FRAME_DONE), 0);
        chk("rst_count",   32'(FRAME_COUNT), 0);
        chk("rst_line_ovf", 32'(LINE_OVF), 0);
        chk("rst_frame_ovf", 32'(FRAME_OVF), 0);
        RESET = 1'b0;

        // HREF before any VSYNC cycle must be ignored
        repeat (4) send_px(8'hF8, 8'h00);
        line_end();
        chk("idle_no_write", 32'(wq.size()), 0);

        // Single-pixel latency: byte1 edge n, W_EN visible only after edge n+1
        start_frame(1'b0, 1'b1);
        HREF = 1'b1; D = 8'hF8;
        step();
        D = 8'h00;
        step();
        chk("lat_n_w_en", 32'(W_EN), 0);
        HREF = 1'b0;
        step();
        chk("lat_n1_w_en", 32'(W_EN), 1);
        chk("lat_n1_data", 32'(W_DATA), 32'h E0);
        chk("lat_n1_addr", 32'(W_ADDR), 0);
        step();
        chk("lat_n2_w_en", 32'(W_EN), 0);
        chk("lat_hold_data", 32'(W_DATA), 32'h E0);
        end_frame();
        exp_count++;
        chk("lat_count", 32'(FRAME_COUNT), 32'(exp_count));

        for (int i = 0; i < 6; i++) begin
            wq.delete();
            start_frame(cv[i].fmt, 1'b1);
            send_px(cv[i].b0, cv[i].b1);
            line_end();
            end_frame();
            exp_count++;
            chk("conv_nwrites", 32'(wq.size()), 1);
            e = (wq.size() > 0) ? wq[0] : '1;
            chk("conv_data", 32'(e[7:0]), 32'(cv[i].exp));
            chk("conv_addr", 32'(e[22:8]), 0);
        end
        chk("conv_count", 32'(FRAME_COUNT), 32'(exp_count));

        // Full screen frame
        wq.delete(); d0 = done_cnt;
        start_frame(1'b0, 1'b1);
        for (int y = 0; y < 6; y++) begin
            for (int x = 0; x < 8; x++) send_px(8'hF8, 8'h00);
            line_end();
        end
        end_frame();
        exp_count++;
        chk("full_nwrites", 32'(wq.size()), 48);
        bad = 0;
        foreach (wq[i]) if (wq[i] !== {15'(i), 8'hE0}) bad++;
        chk("full_seq_bad", 32'(bad), 0);
        e = (wq.size() > 0) ? wq[wq.size()-1] : '1;
        chk("full_last_addr", 32'(e[22:8]), 47);
        chk("full_done_pulses", 32'(done_cnt - d0), 1);
        chk("full_count", 32'(FRAME_COUNT), 32'(exp_count));
        chk("full_line_ovf", 32'(LINE_OVF), 0);
        chk("full_frame_ovf", 32'(FRAME_OVF), 0);

        // FMT change mid-frame has no effect until the next frame
        wq.delete();
        start_frame(1'b1, 1'b1);
        send_px(8'h0F, 8'hF0);
        line_end();
        FMT = 1'b0;
        send_px(8'h0F, 8'hF0);
        line_end();
        end_frame();
        exp_count++;
        chk("fmt_nwrites", 32'(wq.size()), 2);
        e = (wq.size() > 1) ? wq[1] : '1;
        chk("fmt_mid_data", 32'(e[7:0]), 32'h FC);
        chk("fmt_mid_addr", 32'(e[22:8]), 8);

        // Overlong lines and too many lines
        wq.delete();
        start_frame(1'b0, 1'b1);
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 10; x++) send_px(8'h07, 8'h18);
            line_end();
        end
        end_frame();
        exp_count++;
        chk("ovf_nwrites", 32'(wq.size()), 48);
        e = (wq.size() > 0) ? wq[wq.size()-1] : '1;
        chk("ovf_last_addr", 32'(e[22:8]), 47);
        chk("ovf_line", 32'(LINE_OVF), 1);
        chk("ovf_frame", 32'(FRAME_OVF), 1);
        start_frame(1'b0, 1'b1);
        chk("ovf_line_clr", 32'(LINE_OVF), 0);
        chk("ovf_frame_clr", 32'(FRAME_OVF), 0);
        end_frame();
        exp_count++;

        // Skipped frame
        wq.delete(); d0 = done_cnt;
        start_frame(1'b0, 1'b0);
        for (int y = 0; y < 2; y++) begin
            for (int x = 0; x < 8; x++) send_px(8'hF8, 8'h00);
            line_end();
        end
        end_frame();
        chk("skip_nwrites", 32'(wq.size()), 0);
        chk("skip_done", 32'(done_cnt - d0), 0);
        chk("skip_count", 32'(FRAME_COUNT), 32'(exp_count));

        // VSYNC rising while HREF is still high
        wq.delete();
        start_frame(1'b0, 1'b1);
        for (int x = 0; x < 8; x++) send_px(8'hF8, 8'h00);
        line_end();
        for (int x = 0; x < 3; x++) send_px(8'hA5, 8'h5A);
        VSYNC = 1'b1;
        step();
        chk("vs_href_done_hi", 32'(FRAME_DONE), 1);
        step();
        chk("vs_href_done_lo", 32'(FRAME_DONE), 0);
        HREF = 1'b0;
        repeat (3) step();
        exp_count++;
        chk("vs_href_nwrites", 32'(wq.size()), 11);
        e = (wq.size() > 10) ? wq[10] : '1;
        chk("vs_href_last", 32'(e), 32'({15'd10, 8'hB7}));
        chk("vs_href_count", 32'(FRAME_COUNT), 32'(exp_count));

        // Reset mid-frame: nothing written until a full VSYNC cycle is seen
        start_frame(1'b0, 1'b1);
        for (int y = 0; y < 3; y++) begin
            for (int x = 0; x < 8; x++) send_px(8'hF8, 8'h00);
            line_end();
        end
        for (int x = 0; x < 4; x++) send_px(8'hF8, 8'h00);
        RESET = 1'b1;
        step();
        wq.delete();
        step();
        RESET = 1'b0;
        for (int x = 0; x < 4; x++) send_px(8'hF8, 8'h00);
        line_end();
        for (int y = 0; y < 2; y++) begin
            for (int x = 0; x < 8; x++) send_px(8'hF8, 8'h00);
            line_end();
        end
        chk("rstmid_nwrites", 32'(wq.size()), 0);
        chk("rstmid_count", 32'(FRAME_COUNT), 0);
        exp_count = 0;
        d0 = done_cnt;
        start_frame(1'b0, 1'b1);
        chk("rstmid_no_done", 32'(done_cnt - d0), 0);
        send_px(8'h07, 8'h18);
        send_px(8'hF8, 8'h00);
        line_end();
        end_frame();
        exp_count++;
        chk("rstmid_resync_n", 32'(wq.size()), 2);
        e = (wq.size() > 0) ? wq[0] : '1;
        chk("rstmid_first", 32'(e), 32'({15'd0, 8'h1F}));
        chk("rstmid_count2", 32'(FRAME_COUNT), 32'(exp_count));

        // 2x2 decimation on a 16x12 input: input pixel (2,2) lands at 1*8+1
        wq2.delete();
        start_frame(1'b0, 1'b1);
        for (int y = 0; y < 12; y++) begin
            for (int x = 0; x < 16; x++)
                send_px((x == 2 && y == 2) ? 8'hF8 : 8'h00, 8'h00);
            line_end();
        end
        end_frame();
        chk("decim_nwrites", 32'(wq2.size()), 48);
        hits = 0; hit_addr = -1;
        foreach (wq2[i]) if (wq2[i][7:0] == 8'hE0) begin hits++; hit_addr = int'(wq2[i][13:8]); end
        chk("decim_marker_hits", 32'(hits), 1);
        chk("decim_marker_addr", 32'(hit_addr), 9);
        chk("decim_line_ovf", 32'(line_ovf2), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
